// File: rtl/video_timing_gen.sv
// Raster timing source: free-running pixel/line counters with sync, blank and
// per-frame strobe, all registered from the next-pixel values so they never skew.
module video_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int FRAME_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  output logic [10:0]        hcount,
  output logic [9:0]         vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic               new_frame,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEGIN = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEGIN = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  if (H_TOTAL > 2048) begin : g_h_total_illegal
    $error("video_timing_gen: H_TOTAL %0d exceeds 2048", H_TOTAL);
  end
  if (V_TOTAL > 1024) begin : g_v_total_illegal
    $error("video_timing_gen: V_TOTAL %0d exceeds 1024", V_TOTAL);
  end

  logic [10:0]        hcount_q, hcount_d;
  logic [9:0]         vcount_q, vcount_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               blank_q, blank_d;
  logic               new_frame_q, new_frame_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;

  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (int'(hcount_q) == H_TOTAL - 1) begin
      hcount_d = 11'd0;
      if (int'(vcount_q) == V_TOTAL - 1) vcount_d = 10'd0;
      else                               vcount_d = vcount_q + 10'd1;
    end

    // Decode from the next position so outputs land with the counters.
    hsync_d     = !(int'(hcount_d) >= HS_BEGIN && int'(hcount_d) < HS_END);
    vsync_d     = !(int'(vcount_d) >= VS_BEGIN && int'(vcount_d) < VS_END);
    blank_d     = (int'(hcount_d) >= H_ACTIVE) || (int'(vcount_d) >= V_ACTIVE);
    new_frame_d = (int'(hcount_d) == H_ACTIVE) && (int'(vcount_d) == V_ACTIVE - 1);

    frame_count_d = frame_count_q;
    if (new_frame_d) frame_count_d = frame_count_q + FRAME_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_q       <= 1'b0;
      new_frame_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      new_frame_q   <= new_frame_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign new_frame   = new_frame_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a shrunken raster: expected pixel state is
// derived arithmetically from elapsed cycles and checked through a scoreboard.
module tb_video_timing_gen;

  localparam int HA = 16, HF = 3, HS = 5, HB = 4;
  localparam int VA = 10, VF = 2, VS = 3, VB = 2;
  localparam int FW = 6;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int NF_T = (VA - 1) * HT + HA;

  typedef struct packed {
    logic [10:0]   h;
    logic [9:0]    v;
    logic          hs;
    logic          vs;
    logic          bl;
    logic          nf;
    logic [FW-1:0] fc;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [10:0]   hcount;
  logic [9:0]    vcount;
  logic          hsync, vsync, blank, new_frame;
  logic [FW-1:0] frame_count;

  int checks = 0;
  int errors = 0;
  int t = 0;
  pix_t sb_q[$];

  int mon_cyc = 0, hs_len = 0, vs_len = 0, last_nf = -1, nf_cnt = 0;
  int wrap_seen = 0, printed = 0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .FRAME_W(FW)
  ) dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank),
    .new_frame(new_frame), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Reference: position and frame tally follow from cycles since release.
  function automatic pix_t model(int tc);
    pix_t e;
    int h, v;
    h = tc % HT;
    v = (tc / HT) % VT;
    e.h  = 11'(h);
    e.v  = 10'(v);
    e.hs = !(h >= HA + HF && h < HA + HF + HS);
    e.vs = !(v >= VA + VF && v < VA + VF + VS);
    e.bl = (h >= HA) || (v >= VA);
    e.nf = (h == HA) && (v == VA - 1);
    e.fc = (tc >= NF_T) ? FW'(((tc - NF_T) / FRAME + 1) % (1 << FW)) : '0;
    return e;
  endfunction

  function automatic pix_t sample();
    pix_t a;
    a = {hcount, vcount, hsync, vsync, blank, new_frame, frame_count};
    return a;
  endfunction

  task automatic check(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_reset(string name);
    pix_t a, r;
    a = sample();
    r = '{h: 11'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, bl: 1'b0, nf: 1'b0, fc: '0};
    checks++;
    if (a != r) begin
      errors++;
      $display("FAIL %s: got h=%0d v=%0d hs=%0b vs=%0b bl=%0b nf=%0b fc=%0d, expected reset values",
               name, a.h, a.v, a.hs, a.vs, a.bl, a.nf, a.fc);
    end
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(posedge clk);
      t++;
      sb_q.push_back(model(t));
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    #2 rst = 1'b0;
    t = 0;
    #1 check_reset("after_release");
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      mon_cyc = 0; hs_len = 0; vs_len = 0; last_nf = -1; nf_cnt = 0;
    end else begin
      mon_cyc++;
      if (sb_q.size() > 0) begin
        pix_t e, a;
        e = sb_q.pop_front();
        a = sample();
        checks++;
        if (a != e) begin
          errors++;
          if (printed < 20)
            $display("FAIL scoreboard cyc=%0d: got h=%0d v=%0d hs=%0b vs=%0b bl=%0b nf=%0b fc=%0d, expected h=%0d v=%0d hs=%0b vs=%0b bl=%0b nf=%0b fc=%0d",
                     mon_cyc, a.h, a.v, a.hs, a.vs, a.bl, a.nf, a.fc,
                     e.h, e.v, e.hs, e.vs, e.bl, e.nf, e.fc);
          printed++;
        end
      end
      if (!hsync) begin
        if (hs_len == 0) check("hsync_start_col", int'(hcount), HA + HF);
        hs_len++;
      end else if (hs_len != 0) begin
        check("hsync_width", hs_len, HS);
        hs_len = 0;
      end
      if (!vsync) begin
        if (vs_len == 0) check("vsync_start_line", int'(vcount), VA + VF);
        vs_len++;
      end else if (vs_len != 0) begin
        check("vsync_width_cycles", vs_len, VS * HT);
        vs_len = 0;
      end
      if (new_frame) begin
        if (last_nf >= 0) check("frame_period", mon_cyc - last_nf, FRAME);
        last_nf = mon_cyc;
        nf_cnt++;
        check("frame_count_at_strobe", int'(frame_count), nf_cnt % (1 << FW));
        if (frame_count == '0) wrap_seen = 1;
      end
    end
  end

  initial begin
    int exp_nf;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 check_reset("in_reset");
    release_rst();

    run(3 * FRAME + $urandom_range(0, HT - 1));

    for (int i = 0; i < 3; i++) begin
      run($urandom_range(HT, FRAME - 1));
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset("async_reset_midframe");
      repeat ($urandom_range(1, 6)) @(posedge clk);
      release_rst();
      run(1);
      @(negedge clk);
      #1 check("restart_hcount", int'(hcount), 1);
    end

    run(65 * FRAME + $urandom_range(1, FRAME - 1));
    @(negedge clk);
    #1;
    exp_nf = (t >= NF_T) ? (t - NF_T) / FRAME + 1 : 0;
    check("new_frame_pulses", nf_cnt, exp_nf);
    check("frame_count_wrapped", wrap_seen, 1);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
